cw305_prog_bridge_ctrl: RTL and testbench

CW305_PROG_BRIDGE_CTRL -- requirements
Module: cw305_prog_bridge_ctrl

---
 rtl/cw305_prog_bridge_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cw305_prog_bridge_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cw305_prog_bridge_ctrl.sv
`timescale 1ns/1ps
// Program-load bridge: turns register-file instruction/address flags into single-word
// bus writes, with 4-phase clear handshakes back to the usb_clk status register.
module cw305_prog_bridge_ctrl #(
   parameter int unsigned                  pINSTR_WIDTH = 32,
   parameter logic [pINSTR_WIDTH-1:0]      pBASE_ADDR   = '0,
   parameter int unsigned                  pGNT_TIMEOUT = 255
) (
   input  logic                    crypto_clk,
   input  logic                    reset_n,
   input  logic [7:0]              I_status,
   input  logic [pINSTR_WIDTH-1:0] I_instruction,
   input  logic [pINSTR_WIDTH-1:0] I_address,
   output logic                    O_reset_instr_valid,
   output logic                    O_reset_new_addr_valid,
   output logic                    O_bus_req,
   output logic                    O_bus_we,
   output logic [pINSTR_WIDTH-1:0] O_bus_addr,
   output logic [pINSTR_WIDTH-1:0] O_bus_wdata,
   output logic [3:0]              O_bus_be,
   input  logic                    I_bus_gnt,
   input  logic                    I_bus_rvalid,
   output logic                    O_busy,
   output logic                    O_error,
   output logic [15:0]             O_word_count
);

   localparam int unsigned LP_TW = (pGNT_TIMEOUT > 1) ? $clog2(pGNT_TIMEOUT) : 1;
   localparam logic [LP_TW-1:0] LP_TMO_LAST = LP_TW'(pGNT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD_ADDR,
      ST_REQ,
      ST_RESP,
      ST_ACK_INSTR,
      ST_ACK_ADDR,
      ST_ERR
   } state_t;

   state_t                  r_state;
   logic [2:0]              r_sync1;
   logic [2:0]              r_sync2;
   logic [pINSTR_WIDTH-1:0] r_ptr;
   logic [LP_TW-1:0]        r_tmo;
   logic                    r_bus_req;
   logic                    r_bus_we;
   logic [3:0]              r_bus_be;
   logic [pINSTR_WIDTH-1:0] r_bus_addr;
   logic [pINSTR_WIDTH-1:0] r_bus_wdata;
   logic                    r_clr_instr_n;
   logic                    r_clr_addr_n;
   logic                    r_busy;
   logic                    r_error;
   logic [15:0]             r_word_count;

   logic                    w_s_mode;
   logic                    w_s_instr;
   logic                    w_s_addr;
   logic [4:0]              w_unused_status;

   assign w_s_mode        = r_sync2[0];
   assign w_s_instr       = r_sync2[1];
   assign w_s_addr        = r_sync2[2];
   assign w_unused_status = I_status[7:3];

   always_ff @(posedge crypto_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= I_status[2:0];
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge crypto_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_ptr         <= pBASE_ADDR;
         r_tmo         <= '0;
         r_bus_req     <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_be      <= '0;
         r_bus_addr    <= '0;
         r_bus_wdata   <= '0;
         r_clr_instr_n <= 1'b1;
         r_clr_addr_n  <= 1'b1;
         r_busy        <= 1'b0;
         r_error       <= 1'b0;
         r_word_count  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (I_bus_rvalid) begin
                  r_state <= ST_ERR;
                  r_busy  <= 1'b1;
               end else if (!w_s_mode) begin
                  r_error      <= 1'b0;
                  r_word_count <= '0;
                  r_ptr        <= pBASE_ADDR;
               end else if (w_s_addr) begin
                  r_state <= ST_LD_ADDR;
                  r_busy  <= 1'b1;
               end else if (w_s_instr) begin
                  r_state     <= ST_REQ;
                  r_busy      <= 1'b1;
                  r_tmo       <= '0;
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= 1'b1;
                  r_bus_be    <= 4'hF;
                  r_bus_addr  <= r_ptr;
                  r_bus_wdata <= I_instruction;
               end
            end
            ST_LD_ADDR: begin
               if (I_bus_rvalid) begin
                  r_state <= ST_ERR;
               end else begin
                  if (I_address[1:0] != 2'b00) r_error <= 1'b1;
                  else                         r_ptr   <= I_address;
                  r_clr_addr_n <= 1'b0;
                  r_state      <= ST_ACK_ADDR;
               end
            end
            ST_REQ: begin
               // Request, write enable and strobes all retire together on grant, stray response or timeout.
               if (I_bus_gnt) begin
                  r_bus_req <= 1'b0;
                  r_bus_we  <= 1'b0;
                  r_bus_be  <= '0;
                  r_state   <= ST_RESP;
               end else if (I_bus_rvalid) begin
                  r_bus_req <= 1'b0;
                  r_bus_we  <= 1'b0;
                  r_bus_be  <= '0;
                  r_state   <= ST_ERR;
               end else if (r_tmo == LP_TMO_LAST) begin
                  r_bus_req     <= 1'b0;
                  r_bus_we      <= 1'b0;
                  r_bus_be      <= '0;
                  r_error       <= 1'b1;
                  r_clr_instr_n <= 1'b0;
                  r_state       <= ST_ACK_INSTR;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            ST_RESP: begin
               if (I_bus_rvalid) begin
                  r_ptr         <= r_ptr + pINSTR_WIDTH'(4);
                  r_word_count  <= r_word_count + 16'd1;
                  r_clr_instr_n <= 1'b0;
                  r_state       <= ST_ACK_INSTR;
               end
            end
            ST_ACK_INSTR: begin
               // A stray response here is flagged but must not break the handshake in flight.
               if (I_bus_rvalid) r_error <= 1'b1;
               if (!w_s_instr) begin
                  r_clr_instr_n <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            ST_ACK_ADDR: begin
               if (I_bus_rvalid) r_error <= 1'b1;
               if (!w_s_addr) begin
                  r_clr_addr_n <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            ST_ERR: begin
               r_error <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign O_reset_instr_valid    = r_clr_instr_n;
   assign O_reset_new_addr_valid = r_clr_addr_n;
   assign O_bus_req              = r_bus_req;
   assign O_bus_we               = r_bus_we;
   assign O_bus_be               = r_bus_be;
   assign O_bus_addr             = r_bus_addr;
   assign O_bus_wdata            = r_bus_wdata;
   assign O_busy                 = r_busy;
   assign O_error                = r_error;
   assign O_word_count           = r_word_count;

endmodule

// File: tb/tb_cw305_prog_bridge_ctrl.sv
`timescale 1ns/1ps
// Bench for cw305_prog_bridge_ctrl: vector table of flag transactions, write scoreboard,
// and hand-written timeout / stray-response / async-reset sequences.
module tb_cw305_prog_bridge_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  status = '0;
   logic [31:0] instr = '0;
   logic [31:0] address = '0;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;

   logic        O_reset_instr_valid, O_reset_new_addr_valid;
   logic        O_bus_req, O_bus_we, O_busy, O_error;
   logic [31:0] O_bus_addr, O_bus_wdata;
   logic [3:0]  O_bus_be;
   logic [15:0] O_word_count;

   always #5 clk = ~clk;

   cw305_prog_bridge_ctrl #(
      .pINSTR_WIDTH (32),
      .pBASE_ADDR   (32'h0000_0000),
      .pGNT_TIMEOUT (255)
   ) dut (
      .crypto_clk             (clk),
      .reset_n                (rst_n),
      .I_status               (status),
      .I_instruction          (instr),
      .I_address              (address),
      .O_reset_instr_valid    (O_reset_instr_valid),
      .O_reset_new_addr_valid (O_reset_new_addr_valid),
      .O_bus_req              (O_bus_req),
      .O_bus_we               (O_bus_we),
      .O_bus_addr             (O_bus_addr),
      .O_bus_wdata            (O_bus_wdata),
      .O_bus_be               (O_bus_be),
      .I_bus_gnt              (gnt),
      .I_bus_rvalid           (rvalid),
      .O_busy                 (O_busy),
      .O_error                (O_error),
      .O_word_count           (O_word_count)
   );

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t sb[$];

   typedef struct {
      bit          do_addr;
      bit          do_instr;
      logic [31:0] addr;
      logic [31:0] data;
      int          gdly;
      logic [31:0] exp_waddr;
      logic        exp_err;
      logic [15:0] exp_cnt;
   } vec_t;
   vec_t vt[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every granted write is popped and compared against the queued expectation.
   always @(negedge clk) begin
      if (rst_n && O_bus_req && gnt) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_write: got addr %0h expected no write", O_bus_addr);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", O_bus_addr, e.addr);
            check("wr_data", O_bus_wdata, e.data);
            check("wr_we_be", {O_bus_we, O_bus_be}, {1'b1, 4'hF});
         end
      end
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return O_bus_req;
         1:       return O_reset_instr_valid;
         2:       return O_reset_new_addr_valid;
         default: return O_busy;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_sig(input int which, input logic val, input int max_cyc, input string name);
      int n = 0;
      while (sig(which) !== val && n < max_cyc) begin
         tick(1);
         n++;
      end
      check(name, sig(which), val);
   endtask

   task automatic addr_hs(input logic [31:0] a);
      address   = a;
      status[2] = 1'b1;
      wait_sig(2, 1'b0, 20, "addr_ack_low");
      check("addr_before_instr", O_bus_req, 1'b0);
      status[2] = 1'b0;
      wait_sig(2, 1'b1, 20, "addr_ack_release");
   endtask

   task automatic instr_hs(input logic [31:0] d, input int gdly);
      int n = 0;
      instr     = d;
      status[1] = 1'b1;
      wait_sig(0, 1'b1, 20, "req_rise");
      if (gdly >= 0) begin
         tick(gdly);
         gnt = 1'b1;
         tick(1);
         gnt = 1'b0;
         check("req_drop_after_gnt", O_bus_req, 1'b0);
         tick(1);
         rvalid = 1'b1;
         tick(1);
         rvalid = 1'b0;
      end else begin
         while (O_bus_req === 1'b1 && n < 400) begin
            n++;
            tick(1);
         end
         check("timeout_req_cycles", n, 255);
         check("timeout_err", O_error, 1'b1);
      end
      wait_sig(1, 1'b0, 20, "instr_ack_low");
      status[1] = 1'b0;
      wait_sig(1, 1'b1, 20, "instr_ack_release");
   endtask

   task automatic apply_vec(input int i);
      vec_t v = vt[i];
      if (v.do_instr) sb.push_back('{v.exp_waddr, v.data});
      if (v.do_addr && v.do_instr) status[1] = 1'b1;
      if (v.do_addr) addr_hs(v.addr);
      if (v.do_instr) instr_hs(v.data, v.gdly);
      tick(1);
      check($sformatf("v%0d_err", i), O_error, v.exp_err);
      check($sformatf("v%0d_cnt", i), O_word_count, v.exp_cnt);
      check($sformatf("v%0d_busy", i), O_busy, 1'b0);
   endtask

   task automatic mode_clear();
      status = 8'h00;
      tick(5);
      check("mode_clr_err", O_error, 1'b0);
      check("mode_clr_cnt", O_word_count, 16'd0);
      check("mode_clr_busy", O_busy, 1'b0);
      status = 8'h01;
      tick(3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      //               addr instr address        data           gdly waddr          err   cnt
      vt[0]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,          0, 32'h0,          1'b0, 16'd0};
      vt[1]  = '{1'b0, 1'b1, 32'h0,          32'hDEAD_BEEF, 3, 32'h0000_1000, 1'b0, 16'd1};
      vt[2]  = '{1'b0, 1'b1, 32'h0,          32'h1234_5678, 0, 32'h0000_1004, 1'b0, 16'd2};
      vt[3]  = '{1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 1, 32'h0000_2000, 1'b0, 16'd3};
      vt[4]  = '{1'b1, 1'b0, 32'h0000_1002, 32'h0,          0, 32'h0,          1'b1, 16'd3};
      vt[5]  = '{1'b0, 1'b1, 32'h0,          32'h0BAD_F00D, 2, 32'h0000_2004, 1'b1, 16'd4};
      vt[6]  = '{1'b0, 1'b1, 32'h0,          32'h1111_1111, 0, 32'h0000_0000, 1'b0, 16'd1};
      vt[7]  = '{1'b0, 1'b1, 32'h0,          32'h2222_2222, 0, 32'h0000_0004, 1'b1, 16'd2};
      vt[8]  = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          0, 32'h0,          1'b1, 16'd2};
      vt[9]  = '{1'b0, 1'b1, 32'h0,          32'h4444_4444, 0, 32'hFFFF_FFFC, 1'b1, 16'd3};
      vt[10] = '{1'b0, 1'b1, 32'h0,          32'h5555_5555, 0, 32'h0000_0000, 1'b1, 16'd4};
      vt[11] = '{1'b0, 1'b1, 32'h0,          32'h7777_7777, 0, 32'h0000_0000, 1'b0, 16'd1};

      tick(3);
      check("rst_req", O_bus_req, 1'b0);
      check("rst_clr", {O_reset_instr_valid, O_reset_new_addr_valid}, 2'b11);
      check("rst_busy_err_cnt", {O_busy, O_error, O_word_count}, 18'd0);
      rst_n  = 1'b1;
      status = 8'h01;
      tick(4);

      for (int i = 0; i <= 5; i++) apply_vec(i);
      mode_clear();
      apply_vec(6);

      instr_hs(32'h3333_3333, -1);
      tick(1);
      check("timeout_cnt_kept", O_word_count, 16'd1);

      for (int i = 7; i <= 10; i++) apply_vec(i);

      mode_clear();
      rvalid = 1'b1;
      tick(1);
      rvalid = 1'b0;
      check("stray_rvalid_busy", O_busy, 1'b1);
      tick(1);
      check("stray_rvalid_err", O_error, 1'b1);
      check("stray_rvalid_idle", O_busy, 1'b0);

      sb.push_back('{32'h0000_0000, 32'h6666_6666});
      instr     = 32'h6666_6666;
      status[1] = 1'b1;
      wait_sig(0, 1'b1, 20, "rst_seq_req_rise");
      gnt = 1'b1;
      tick(1);
      gnt = 1'b0;
      check("rst_seq_in_resp_busy", O_busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_bus", {O_bus_req, O_bus_we, O_bus_be}, 6'd0);
      check("async_rst_addr_data", {O_bus_addr, O_bus_wdata}, 64'd0);
      check("async_rst_clr", {O_reset_instr_valid, O_reset_new_addr_valid}, 2'b11);
      check("async_rst_busy_err_cnt", {O_busy, O_error, O_word_count}, 18'd0);
      status = 8'h01;
      tick(2);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         seen = seen | O_bus_req | O_busy;
      end
      check("no_activity_after_reset", seen, 1'b0);
      apply_vec(11);

      tick(2);
      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
